// File: rtl/rot_coord_mapper.sv
// rot_coord_mapper: fetches cos/sin for a commanded angle from the LUT, then rotates a valid/ready stream of coordinates
module rot_coord_mapper #(
  parameter int CW = 11,
  parameter int LUT_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           angle_idx,
  input  logic                 angle_neg,
  output logic [2:0]           aci,
  output logic                 eksi,
  output logic                 mode_switch,
  input  logic signed [16:0]   lut_out,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_x,
  input  logic signed [CW-1:0] in_y,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] out_x,
  output logic signed [CW-1:0] out_y,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, REQ_COS, REQ_SIN, RUN, DRAIN} state_t;
  localparam int CNTW = $clog2(LUT_LAT + 2);
  localparam logic signed [CW+17:0] HALF = (CW+18)'(512);
  localparam logic signed [CW+17:0] MAXV = (CW+18)'(2 ** (CW - 1) - 1);
  localparam logic signed [CW+17:0] MINV = (CW+18)'(-(2 ** (CW - 1)));
  state_t state, state_nx;
  logic [CNTW-1:0] cnt;
  logic signed [16:0] cos_r, sin_r;
  logic signed [CW+16:0] p_xc, p_ys, p_xs, p_yc;
  logic signed [CW+17:0] s_x, s_y;
  logic cnt_done, fetch, xfer, accept;
  function automatic logic [CW-1:0] sat(input logic signed [CW+17:0] v);
    logic signed [CW+17:0] r;
    r = (v + HALF) >>> 10;
    return r > MAXV ? MAXV[CW-1:0] : r < MINV ? MINV[CW-1:0] : r[CW-1:0];
  endfunction
  assign cnt_done = cnt == CNTW'(LUT_LAT);
  assign fetch = state == REQ_COS || state == REQ_SIN;
  assign xfer = in_valid && in_ready;
  assign accept = out_valid && out_ready;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? REQ_COS : IDLE;
      REQ_COS: state_nx = cnt_done ? REQ_SIN : REQ_COS;
      REQ_SIN: state_nx = cnt_done ? RUN : REQ_SIN;
      RUN:     state_nx = xfer && in_last ? DRAIN : RUN;
      DRAIN:   state_nx = accept ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb
    in_ready = state == RUN && (!out_valid || out_ready);
  always_comb begin
    p_xc = (CW+17)'(in_x) * (CW+17)'(cos_r);
    p_ys = (CW+17)'(in_y) * (CW+17)'(sin_r);
    p_xs = (CW+17)'(in_x) * (CW+17)'(sin_r);
    p_yc = (CW+17)'(in_y) * (CW+17)'(cos_r);
    s_x = (CW+18)'(p_xc) - (CW+18)'(p_ys);
    s_y = (CW+18)'(p_xs) + (CW+18)'(p_yc);
  end
  always_ff @(posedge clk)
    if (reset) begin
      aci <= '0;
      eksi <= 1'b0;
      mode_switch <= 1'b0;
      cnt <= '0;
      cos_r <= '0;
      sin_r <= '0;
      out_valid <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt <= fetch && !cnt_done ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        aci <= angle_idx;
        eksi <= angle_neg;
        mode_switch <= 1'b0;
        busy <= 1'b1;
      end
      if (state == REQ_COS && cnt_done) begin
        cos_r <= lut_out;
        mode_switch <= 1'b1;
      end
      if (state == REQ_SIN && cnt_done)
        sin_r <= lut_out;
      if (xfer) begin
        out_valid <= 1'b1;
        out_x <= sat(s_x);
        out_y <= sat(s_y);
      end else if (out_ready)
        out_valid <= 1'b0;
      if (state == DRAIN && accept) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
endmodule
